// File: rtl/hazard_scoreboard_if.sv
// FD-side hazard interface: FD latch, writeback and mult/div
// status inputs, plus the stall/issue/busy/error results.
interface hazard_scoreboard_if #(
  parameter int REG_W = 5
);
  logic [31:0]      fd_ir;
  logic             fd_valid;
  logic             wb_valid;
  logic [REG_W-1:0] wb_rd;
  logic             md_ready;
  logic             stall;
  logic             issue;
  logic             md_busy;
  logic             hazard_err;

  modport master (
    output fd_ir, fd_valid, wb_valid, wb_rd, md_ready,
    input  stall, issue, md_busy, hazard_err
  );

  modport slave (
    input  fd_ir, fd_valid, wb_valid, wb_rd, md_ready,
    output stall, issue, md_busy, hazard_err
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Stall/hazard unit beside the FD latch: pending-write scoreboard,
// load-use tracker, mult/div busy hold and stall watchdog.
module hazard_scoreboard #(
  parameter int NUM_REGS  = 32,
  parameter int REG_W     = 5,
  parameter int MAX_INFL  = 3,
  parameter int FWD_EN    = 0,
  parameter int STALL_MAX = 64
) (
  input logic clock,
  input logic reset,
  hazard_scoreboard_if.slave hz
);
  localparam int CNT_W = $clog2(MAX_INFL + 1);
  localparam int SC_W  = (STALL_MAX > 0) ? $clog2(STALL_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFL);
  localparam logic [SC_W-1:0]  SC_MAX  = SC_W'(STALL_MAX);

  localparam logic [4:0] OP_R    = 5'b00000;
  localparam logic [4:0] OP_BNE  = 5'b00010;
  localparam logic [4:0] OP_JAL  = 5'b00011;
  localparam logic [4:0] OP_JR   = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_BLT  = 5'b00110;
  localparam logic [4:0] OP_SW   = 5'b00111;
  localparam logic [4:0] OP_LW   = 5'b01000;
  localparam logic [4:0] OP_SETX = 5'b10101;
  localparam logic [4:0] OP_BEX  = 5'b10110;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  logic [CNT_W-1:0] cnt [NUM_REGS];
  logic [0:0]       md_st;
  logic             dx_load;
  logic [REG_W-1:0] dx_rd;
  logic [SC_W-1:0]  scnt;
  logic [SC_W-1:0]  scnt_nxt;
  logic             err;

  logic [4:0]       op;
  logic [4:0]       fn;
  logic [REG_W-1:0] f_rd;
  logic [REG_W-1:0] f_rs;
  logic [REG_W-1:0] f_rt;
  logic [REG_W-1:0] s1;
  logic [REG_W-1:0] s2;
  logic [REG_W-1:0] dst;
  logic             is_ld;
  logic             is_md;
  logic             live;
  logic             hazard;
  logic             stall;
  logic             issue;
  logic             inc_v;
  logic             dec_v;
  logic             same;
  logic             ovf;
  logic             unf;
  logic             wd_hit;
  logic             unused_bits;

  assign op   = hz.fd_ir[31:27];
  assign fn   = hz.fd_ir[6:2];
  assign f_rd = REG_W'(hz.fd_ir[26:22]);
  assign f_rs = REG_W'(hz.fd_ir[21:17]);
  assign f_rt = REG_W'(hz.fd_ir[16:12]);
  assign unused_bits = ^{hz.fd_ir[11:7], hz.fd_ir[1:0]};

  // r0 doubles as "no operand", so a zero src/dst is never tracked
  always_comb begin
    s1    = '0;
    s2    = '0;
    dst   = '0;
    is_ld = 1'b0;
    is_md = 1'b0;
    unique case (1'b1)
      op == OP_R: begin
        s1    = f_rs;
        s2    = f_rt;
        dst   = f_rd;
        is_md = (fn == 5'b00110) || (fn == 5'b00111);
      end
      op == OP_ADDI: begin
        s1  = f_rs;
        dst = f_rd;
      end
      op == OP_LW: begin
        s1    = f_rs;
        dst   = f_rd;
        is_ld = 1'b1;
      end
      op == OP_SW: begin
        s1 = f_rs;
        s2 = f_rd;
      end
      (op == OP_BNE) || (op == OP_BLT): begin
        s1 = f_rd;
        s2 = f_rs;
      end
      op == OP_JR:   s1  = f_rd;
      op == OP_JAL:  dst = REG_W'(31);
      op == OP_SETX: dst = REG_W'(30);
      op == OP_BEX:  s1  = REG_W'(30);
      default: ;
    endcase
  end

  assign live = hz.fd_valid && (hz.fd_ir != 32'd0);

  always_comb begin
    hazard = 1'b0;
    if (FWD_EN != 0)
      hazard = dx_load &&
               (((s1 != '0) && (s1 == dx_rd)) ||
                ((s2 != '0) && (s2 == dx_rd)));
    else
      hazard = ((s1 != '0) && (cnt[s1] != '0)) ||
               ((s2 != '0) && (cnt[s2] != '0));
    hazard = hazard && live;
  end

  assign stall = hazard || ((md_st == S_BUSY) && !hz.md_ready);
  assign issue = live && !stall;

  assign inc_v = issue && (dst != '0);
  assign dec_v = hz.wb_valid && (hz.wb_rd != '0);
  assign same  = inc_v && dec_v && (dst == hz.wb_rd);
  assign ovf   = inc_v && !same && (cnt[dst] == CNT_MAX);
  assign unf   = dec_v && !same && (cnt[hz.wb_rd] == '0);

  always_comb begin
    scnt_nxt = '0;
    if (stall)
      scnt_nxt = (scnt == SC_MAX) ? scnt : scnt + SC_W'(1);
  end

  assign wd_hit = (STALL_MAX != 0) && stall && (scnt_nxt == SC_MAX);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NUM_REGS; r++)
        cnt[r] <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (r == 0)
          cnt[r] <= '0;
        else if (inc_v && (dst == REG_W'(r)) && !same &&
                 (cnt[r] != CNT_MAX))
          cnt[r] <= cnt[r] + CNT_W'(1);
        else if (dec_v && (hz.wb_rd == REG_W'(r)) && !same &&
                 (cnt[r] != '0))
          cnt[r] <= cnt[r] - CNT_W'(1);
      end
    end
  end

  // A mult/div may issue on the md_ready cycle and re-arm BUSY
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      md_st   <= S_IDLE;
      dx_load <= 1'b0;
      dx_rd   <= '0;
      scnt    <= '0;
      err     <= 1'b0;
    end else begin
      if (issue && is_md)
        md_st <= S_BUSY;
      else if (hz.md_ready)
        md_st <= S_IDLE;
      dx_load <= issue && is_ld;
      if (issue)
        dx_rd <= dst;
      scnt <= scnt_nxt;
      err  <= err || ovf || unf || wd_hit;
    end
  end

  assign hz.stall      = stall;
  assign hz.issue      = issue;
  assign hz.md_busy    = (md_st == S_BUSY);
  assign hz.hazard_err = err;
endmodule
